traffic_light_key_in: RTL and testbench
=======================================

# traffic_light_key_in

Avalon-MM slave input port with edge capture and interrupt, the read-side counterpart to the traffic light's 4-bit output PIO. It samples the DE10-Lite push buttons and switches, synchronises and optionally debounces them, latches selected edges into a write-1-to-clear capture register, and raises `irq` to the Nios II when an unmasked edge is pending.

## Interface
Parameters:
- `WIDTH`, 4: number of input bits.
- `EDGE_TYPE`, 1: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.
- `IDLE_LEVEL`, 1: reset value of every synchroniser and filter flop. Keys idle high.
- `DEBOUNCE`, 0: stable cycles required before the filtered value follows the synchronised input. 0 bypasses the filter.

Ports:
- `clk`, in, 1: single clock for all logic.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `address`, in, 2: word address.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe.
- `writedata`, in, 32: write data. Only `[WIDTH-1:0]` is used.
- `in_port`, in, WIDTH: asynchronous external inputs.
- `readdata`, out, 32: registered read data. Reset value 0.
- `irq`, out, 1: level interrupt. Reset value 0.

## Operation
- **Synchroniser:** 2-flop synchroniser per bit. Both flops reset to `IDLE_LEVEL`.
- **Debounce filter** (`DEBOUNCE` > 0):
  - Each bit has a counter of width clog2(`DEBOUNCE`+1).
  - The counter clears whenever the synchronised value equals the filtered value.
  - Otherwise it increments. On reaching `DEBOUNCE`, the filtered value takes the synchronised value and the counter clears.
  - The filtered value resets to `IDLE_LEVEL`; counters reset to 0.
  - With `DEBOUNCE` = 0, filtered = synchronised.
- **Edge detect:**
  - `prev` register holds filtered, delayed 1 cycle. It resets to `IDLE_LEVEL`, so no spurious edge occurs out of reset.
  - rise = filt & ~prev; fall = ~filt & prev; any = rise | fall.
- **Register map** (word addresses):
  - 0, data: read-only, returns filtered value. Writes ignored.
  - 1, reserved: reads 0, writes ignored.
  - 2, irq_mask: read/write, bits `[WIDTH-1:0]`. Reset value 0.
  - 3, edge_capture: read/write-1-to-clear. A write with `chipselect` = 1, `write_n` = 0, `address` = 3 clears each bit where `writedata` is 1. Reset value 0.
- **Capture:** a detected edge sets its bit, and the bit stays set until cleared by software.
- **Simultaneous edge and clear** on the same bit in the same cycle: the edge wins and the bit stays 1.
- **irq:** `irq` = |(edge_capture & irq_mask). It is combinational from flops only, with no input-to-output path.
- **Read data:**
  - `readdata` loads {zero-extend, mux(address)} on every clock edge, whether or not `chipselect` is asserted.
  - Unused upper bits are 0.
  - Reads have no side effects; reading edge_capture does not clear it.
- **Reset mid-operation:** all state returns to its reset values in the same cycle, asynchronously. Pending captures and debounce progress are lost.

## Timing
- **Read latency:** 1 cycle. `readdata` holds the value for the `address` presented at the previous rising edge. No wait states.
- **Write:** takes effect at the rising edge where the write is presented. A read of the same register in the next cycle returns the new value.
- **Input to capture** (`DEBOUNCE` = 0):
  - An `in_port` change that is stable before edge k appears at the synchroniser output after edge k+1.
  - The capture bit is set after edge k+2, and `irq` rises in the same cycle if the bit is unmasked.
- **Input to capture** (`DEBOUNCE` = N): add N cycles of stable synchronised input.
- **Glitch rejection:** a pulse shorter than N synchronised cycles produces no filtered change and no capture.
- **irq timing:**
  - `irq` deasserts the cycle after a clearing write to edge_capture, or after a mask write that clears the relevant bit.
  - `irq` stays asserted if another unmasked bit is still set, or if the edge-wins rule applied.

## Structure
- **Shared package `traffic_light_pkg`:**
  - Register address constants: `ADDR_DATA` = 0, `ADDR_IRQMASK` = 2, `ADDR_EDGECAP` = 3.
  - `EDGE_TYPE` encodings: `EDGE_RISE`, `EDGE_FALL`, `EDGE_ANY`.
- **Sub-module `traffic_light_debounce`:**
  - One instance per bit, created in a generate loop.
  - Contains the synchroniser, filter counter and filtered output.
  - The top level holds `prev`, edge_capture, irq_mask, the read mux and `irq`.

## Test plan
- **Reset:** assert `reset_n` = 0 with `in_port` = 4'hF. Release reset, then read addresses 0, 2, 3. Required: `readdata` = 0xF, 0x0, 0x0; `irq` = 0; no capture after 10 cycles.
- **Falling edge with interrupt:** write irq_mask = 0x1, then drive `in_port` 4'hF→4'hE. Required: edge_capture = 0x1 within 3 cycles and `irq` = 1. Then write 0x1 to address 3. Required: `irq` = 0 on the next cycle and edge_capture reads 0x0.
- **Masking and edge type:** with `EDGE_TYPE` = 1 and irq_mask = 0, drive bit 2 low then high. Required: edge_capture = 0x4 and `irq` stays 0. Writing irq_mask = 0x4 makes `irq` = 1 next cycle.
- **Clear collision:** time a falling edge on bit 1 so its capture cycle coincides with a write of 0x2 to address 3. Required: edge_capture bit 1 stays 1 and `irq` stays asserted.
- **Debounce** (`DEBOUNCE` = 8): a 5-cycle low pulse on bit 3 gives no capture and data stays 0xF. A 12-cycle low gives edge_capture = 0x8, with data bit 3 reading 0 exactly 8 cycles later than in the `DEBOUNCE` = 0 run.
- **Reset mid-debounce:** with bit 0 low for 4 of 8 cycles, pulse `reset_n` low. Required: counters clear and the filtered value returns to 1. Bit 0 held low afterwards needs a full 8 stable cycles before data bit 0 = 0.

Source files
------------

// File: rtl/traffic_light_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_pkg
//  Description : Shared constants for the traffic-light key input port.
//                Register word addresses and edge-type encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_light_pkg;

    // Word addresses of the slave register map
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge that sets a capture bit
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage : traffic_light_pkg
`default_nettype wire

// File: rtl/traffic_light_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_debounce
//  Description : One input bit: 2-flop synchroniser followed by an optional
//                stable-count debounce filter.
//  Ports       : clk      - clock
//                reset_n  - asynchronous active-low reset
//                in_i     - asynchronous external input bit
//                filt_o   - synchronised (and filtered) bit
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_debounce
    import traffic_light_pkg::*;
#(
    parameter int   DEBOUNCE   = 0,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic filt_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign filt_o = sync2_q;
        end else begin : g_filter
            localparam int              CW       = $clog2(DEBOUNCE + 1);
            // The count that, once incremented, reaches DEBOUNCE
            localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          filt_q;
            logic          filt_d;

            // Counter runs only while the synchronised value disagrees with
            // the filtered value; any agreement restarts the stability count.
            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (sync2_q != filt_q) begin
                    if (cnt_q == CNT_LAST) begin
                        filt_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q  <= '0;
                    filt_q <= IDLE_LEVEL;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end

            assign filt_o = filt_q;
        end
    endgenerate

endmodule : traffic_light_debounce
`default_nettype wire

// File: rtl/traffic_light_key_in.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_key_in
//  Description : Avalon-MM slave input port with edge capture and interrupt
//                for the DE10-Lite keys/switches.
//  Ports       : clk, reset_n          - clock, async active-low reset
//                address[1:0]          - word address
//                chipselect, write_n   - slave select, active-low write
//                writedata[31:0]       - write data ([WIDTH-1:0] used)
//                in_port[WIDTH-1:0]    - asynchronous external inputs
//                readdata[31:0]        - registered read data
//                irq                   - level interrupt to the CPU
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_key_in
    import traffic_light_pkg::*;
#(
    parameter int   WIDTH      = 4,
    parameter int   EDGE_TYPE  = EDGE_FALL,
    parameter logic IDLE_LEVEL = 1'b1,
    parameter int   DEBOUNCE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;

    // ------------------------------------------------------------------
    // Per-bit synchroniser / debounce
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            traffic_light_debounce #(
                .DEBOUNCE   (DEBOUNCE),
                .IDLE_LEVEL (IDLE_LEVEL)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .in_i    (in_port[i]),
                .filt_o  (w_filt[i])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign w_edge = w_filt & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign w_edge = ~w_filt & prev_q;
        end else begin : g_any
            assign w_edge = w_filt ^ prev_q;
        end
    endgenerate

    // Only the low WIDTH bits of writedata carry register content
    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic w_unused_wdata;
            assign w_unused_wdata = ^writedata[31:WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

    // Edge term is OR-ed in after the clear so a same-cycle edge wins.
    assign cap_d  = (cap_q & ~w_clr) | w_edge;
    assign mask_d = (w_wr && (address == ADDR_IRQMASK)) ? writedata[WIDTH-1:0] : mask_q;

    // ------------------------------------------------------------------
    // Read mux, loaded every cycle regardless of chipselect
    // ------------------------------------------------------------------
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[WIDTH-1:0] = w_filt;
            ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: readdata_d[WIDTH-1:0] = cap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= {WIDTH{IDLE_LEVEL}};
            cap_q      <= '0;
            mask_q     <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= w_filt;
            cap_q      <= cap_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    // Driven from flops only; no combinational path from any input.
    assign irq      = |(cap_q & mask_q);

endmodule : traffic_light_key_in
`default_nettype wire

// File: tb/tb_traffic_light_key_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_key_in
//  Description : Self-checking bench. Two instances share the bus and inputs:
//                u_dut0 without debounce and u_dut8 with an 8-cycle filter.
//                A behavioural model is compared every cycle; directed steps
//                add hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_key_in;

    localparam int DEB8 = 8;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] rd0, rd8;
    logic        irq0, irq8;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;
    int t0, t8;

    traffic_light_key_in #(
        .WIDTH(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1), .DEBOUNCE(0)
    ) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    traffic_light_key_in #(
        .WIDTH(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1), .DEBOUNCE(DEB8)
    ) u_dut8 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd8), .irq(irq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: index 0 = no debounce, index 1 = DEB8
    // sync: input seen two edges late; filter: follows sync once sync has
    // disagreed for DEB consecutive cycles; capture: sticky falling edges.
    // ------------------------------------------------------------------
    logic [3:0]  m_s1   [2];
    logic [3:0]  m_s2   [2];
    logic [3:0]  m_filt [2];
    logic [3:0]  m_prev [2];
    logic [3:0]  m_cap  [2];
    logic [3:0]  m_mask [2];
    logic [31:0] m_rd   [2];
    int          m_run  [2][4];

    task automatic model_step();
        logic [3:0] edges;
        logic [3:0] f_new;
        int         d;
        logic       wr;
        wr = chipselect && !write_n;
        for (int n = 0; n < 2; n++) begin
            d = (n == 0) ? 0 : DEB8;
            if (!reset_n) begin
                m_s1[n] = 4'hF; m_s2[n] = 4'hF; m_filt[n] = 4'hF; m_prev[n] = 4'hF;
                m_cap[n] = 4'h0; m_mask[n] = 4'h0; m_rd[n] = 32'h0;
                for (int b = 0; b < 4; b++) m_run[n][b] = 0;
            end else begin
                edges = ~m_filt[n] & m_prev[n];
                case (address)
                    2'd0:    m_rd[n] = {28'h0, m_filt[n]};
                    2'd2:    m_rd[n] = {28'h0, m_mask[n]};
                    2'd3:    m_rd[n] = {28'h0, m_cap[n]};
                    default: m_rd[n] = 32'h0;
                endcase
                if (wr && address == 2'd3) m_cap[n] = m_cap[n] & ~writedata[3:0];
                m_cap[n] = m_cap[n] | edges;
                if (wr && address == 2'd2) m_mask[n] = writedata[3:0];
                m_prev[n] = m_filt[n];
                if (d == 0) begin
                    f_new = m_s1[n];
                end else begin
                    f_new = m_filt[n];
                    for (int b = 0; b < 4; b++) begin
                        if (m_s2[n][b] != m_filt[n][b]) begin
                            m_run[n][b] = m_run[n][b] + 1;
                            if (m_run[n][b] == d) begin
                                f_new[b]    = m_s2[n][b];
                                m_run[n][b] = 0;
                            end
                        end else begin
                            m_run[n][b] = 0;
                        end
                    end
                end
                m_filt[n] = f_new;
                m_s2[n]   = m_s1[n];
                m_s1[n]   = in_port;
            end
        end
    endtask

    // Per-cycle comparison, sampled 1 time unit after the rising edge
    initial begin
        wait (chk_en);
        forever begin
            @(posedge clk);
            #1;
            model_step();
            check("cyc_rd0",  rd0,  m_rd[0]);
            check("cyc_irq0", {31'h0, irq0}, {31'h0, |(m_cap[0] & m_mask[0])});
            check("cyc_rd8",  rd8,  m_rd[1]);
            check("cyc_irq8", {31'h0, irq8}, {31'h0, |(m_cap[1] & m_mask[1])});
        end
    end

    // ------------------------------------------------------------------
    // Bus helpers (called on a falling edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; chipselect = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        reset_n = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 4'hF;
        #3;
        reset_n = 1'b0;
        chk_en  = 1'b1;
        tick(3);
        reset_n = 1'b1;

        // Reset state
        bus_read(2'd0); check("rst_data0", rd0, 32'hF); check("rst_data8", rd8, 32'hF);
        bus_read(2'd2); check("rst_mask0", rd0, 32'h0); check("rst_mask8", rd8, 32'h0);
        bus_read(2'd3); check("rst_cap0",  rd0, 32'h0); check("rst_cap8",  rd8, 32'h0);
        check("rst_irq0", {31'h0, irq0}, 32'h0);
        check("rst_irq8", {31'h0, irq8}, 32'h0);
        tick(10);
        bus_read(2'd3); check("idle_cap0", rd0, 32'h0); check("idle_cap8", rd8, 32'h0);

        // Falling edge on bit 0 with interrupt
        bus_write(2'd2, 32'h1);
        in_port = 4'hE;
        tick(2);
        check("fall_irq0_early", {31'h0, irq0}, 32'h0);
        tick(1);
        check("fall_irq0", {31'h0, irq0}, 32'h1);
        bus_read(2'd3); check("fall_cap0", rd0, 32'h1);
        tick(10);
        check("fall_irq8", {31'h0, irq8}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("clr_irq0", {31'h0, irq0}, 32'h0);
        check("clr_irq8", {31'h0, irq8}, 32'h0);
        bus_read(2'd3); check("clr_cap0", rd0, 32'h0); check("clr_cap8", rd8, 32'h0);
        in_port = 4'hF;
        tick(14);

        // Masked capture on bit 2; rising edge ignored
        bus_write(2'd2, 32'h0);
        in_port = 4'hB;
        tick(14);
        in_port = 4'hF;
        tick(14);
        bus_read(2'd3); check("mask_cap0", rd0, 32'h4); check("mask_cap8", rd8, 32'h4);
        check("mask_irq0", {31'h0, irq0}, 32'h0);
        check("mask_irq8", {31'h0, irq8}, 32'h0);
        bus_write(2'd2, 32'h4);
        check("unmask_irq0", {31'h0, irq0}, 32'h1);
        check("unmask_irq8", {31'h0, irq8}, 32'h1);
        bus_write(2'd3, 32'h4);
        check("unmask_clr_irq0", {31'h0, irq0}, 32'h0);

        // Clear collides with capture of bit 1 (no-debounce instance)
        bus_write(2'd2, 32'h2);
        in_port = 4'hD;
        tick(2);
        bus_write(2'd3, 32'h2);
        check("coll_irq0", {31'h0, irq0}, 32'h1);
        bus_read(2'd3); check("coll_cap0", rd0, 32'h2);
        tick(12);
        bus_write(2'd3, 32'hF);
        check("coll_end_irq0", {31'h0, irq0}, 32'h0);
        check("coll_end_irq8", {31'h0, irq8}, 32'h0);
        in_port = 4'hF;
        tick(14);
        bus_write(2'd2, 32'h0);

        // Debounce: 5-cycle glitch rejected by the filtered instance
        address = 2'd0;
        in_port = 4'h7;
        tick(5);
        in_port = 4'hF;
        tick(15);
        bus_read(2'd0); check("glitch_data8", rd8, 32'hF);
        bus_read(2'd3); check("glitch_cap8", rd8, 32'h0); check("glitch_cap0", rd0, 32'h8);
        bus_write(2'd3, 32'h8);
        address = 2'd0;
        tick(2);

        // Debounce: 12-cycle low passes, 8 cycles behind the unfiltered path
        t0 = -1; t8 = -1;
        in_port = 4'h7;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 12) in_port = 4'hF;
            if (t0 < 0 && rd0[3] == 1'b0) t0 = i;
            if (t8 < 0 && rd8[3] == 1'b0) t8 = i;
        end
        check("deb_t0", t0, 32'd3);
        check("deb_t8", t8, 32'd11);
        check("deb_delta", t8 - t0, 32'd8);
        tick(20);
        bus_read(2'd3); check("deb_cap8", rd8, 32'h8); check("deb_cap0", rd0, 32'h8);
        bus_write(2'd3, 32'hF);

        // Reset part-way through a debounce count
        in_port = 4'hE;
        tick(6);
        reset_n = 1'b0;
        tick(1);
        check("midrst_rd8", rd8, 32'h0);
        reset_n = 1'b1;
        address = 2'd0;
        t0 = -1; t8 = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("midrst_filt8", rd8, 32'hF);
                check("midrst_filt0", rd0, 32'hF);
            end
            if (t0 < 0 && rd0[0] == 1'b0) t0 = i;
            if (t8 < 0 && rd8[0] == 1'b0) t8 = i;
        end
        check("midrst_t0", t0, 32'd3);
        check("midrst_t8", t8, 32'd11);
        in_port = 4'hF;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_traffic_light_key_in
`default_nettype wire
